// File: rtl/conway_pkg.sv
// Shared types and constants for the Game-of-Life row engine.
package conway_pkg;
   localparam int GEN_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      CAPTURE,
      WRITE,
      DONE
   } state_e;
endpackage

// File: rtl/conway_next_row.sv
// Combinational next-generation row from a three-row window.
// Cells outside the row edges are treated as dead.
module conway_cell (
   input  logic [2:0] top,
   input  logic [2:0] mid,
   input  logic [2:0] bot,
   output logic       nxt
);
   logic [3:0] s;

   // s counts the full 3x3 block, centre included
   always_comb begin
      s = 4'd0;
      for (int b = 0; b < 3; b++) begin
         s = s + {3'd0, top[b]} + {3'd0, mid[b]} + {3'd0, bot[b]};
      end
      nxt = (s == 4'd3) | (mid[1] & (s == 4'd4));
   end
endmodule

module conway_next_row #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] top,
   input  logic [WIDTH-1:0] mid,
   input  logic [WIDTH-1:0] bot,
   output logic [WIDTH-1:0] nxt
);
   logic [WIDTH+1:0] top_p;
   logic [WIDTH+1:0] mid_p;
   logic [WIDTH+1:0] bot_p;

   // bit i+1 of the padded rows is column i
   assign top_p = {1'b0, top, 1'b0};
   assign mid_p = {1'b0, mid, 1'b0};
   assign bot_p = {1'b0, bot, 1'b0};

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      conway_cell u_cell (
         .top (top_p[i+2:i]),
         .mid (mid_p[i+2:i]),
         .bot (bot_p[i+2:i]),
         .nxt (nxt[i])
      );
   end
endmodule

// File: rtl/conway_row_engine.sv
// Row sequencer: streams source rows through a three-row window
// and writes one next-generation row per WRITE cycle.
module conway_row_engine
   import conway_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int HEIGHT = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [WIDTH-1:0]  rd_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [WIDTH-1:0]  wr_data,
   output logic [GEN_W-1:0]  gen_count
);
   localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(HEIGHT);

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  top_q, top_d;
   logic [WIDTH-1:0]  mid_q, mid_d;
   logic [WIDTH-1:0]  bot_q, bot_d;
   logic [ADDR_W:0]   f_q, f_d;
   logic [GEN_W-1:0]  gen_q, gen_d;
   logic [WIDTH-1:0]  nxt_row;
   logic              more;

   assign more = (f_q < LAST);

   conway_next_row #(
      .WIDTH (WIDTH)
   ) u_next_row (
      .top (top_q),
      .mid (mid_q),
      .bot (bot_q),
      .nxt (nxt_row)
   );

   always_comb begin
      state_d = state_q;
      top_d   = top_q;
      mid_d   = mid_q;
      bot_d   = bot_q;
      f_d     = f_q;
      gen_d   = gen_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               top_d   = '0;
               mid_d   = '0;
               bot_d   = '0;
               f_d     = '0;
               state_d = FETCH;
            end
         end
         FETCH: state_d = CAPTURE;
         CAPTURE: begin
            top_d = mid_q;
            mid_d = bot_q;
            // past the last row the window fills with dead cells
            bot_d = more ? rd_data : '0;
            if (f_q == '0) begin
               f_d     = (ADDR_W+1)'(1);
               state_d = FETCH;
            end else begin
               state_d = WRITE;
            end
         end
         WRITE: begin
            if (f_q == LAST) begin
               state_d = DONE;
            end else begin
               f_d     = f_q + (ADDR_W+1)'(1);
               state_d = FETCH;
            end
         end
         DONE: begin
            gen_d   = gen_q + GEN_W'(1);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         top_q   <= '0;
         mid_q   <= '0;
         bot_q   <= '0;
         f_q     <= '0;
         gen_q   <= '0;
      end else begin
         state_q <= state_d;
         top_q   <= top_d;
         mid_q   <= mid_d;
         bot_q   <= bot_d;
         f_q     <= f_d;
         gen_q   <= gen_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign rd_en     = (state_q == FETCH) & more;
   assign rd_addr   = rd_en ? f_q[ADDR_W-1:0] : '0;
   assign wr_en     = (state_q == WRITE);
   assign wr_addr   = wr_en ? (f_q[ADDR_W-1:0] - ADDR_W'(1)) : '0;
   assign wr_data   = nxt_row;
   assign gen_count = gen_q;
endmodule

// File: tb/tb_conway_row_engine.sv
// Bench for conway_row_engine: directed Life patterns, random grids,
// cycle timing, start re-pulse and mid-generation reset.
module tb_conway_row_engine;
   localparam int W  = 8;
   localparam int H  = 5;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          busy;
   logic          done;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [W-1:0]  rd_data;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [W-1:0]  wr_data;
   logic [15:0]   gen_count;

   conway_row_engine #(
      .WIDTH  (W),
      .HEIGHT (H),
      .ADDR_W (AW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .gen_count (gen_count)
   );

   always #5 clk = ~clk;

   logic [W-1:0] src [H];
   logic [W-1:0] dst [H];
   int           cyc = 0;
   int           checks = 0;
   int           errors = 0;
   int           gen_exp = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // source RAM: one-cycle read latency, garbage if addressed out of range
   always @(posedge clk) begin
      if (rd_en) rd_data <= (int'(rd_addr) < H) ? src[rd_addr] : 8'hA5;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] ref_row(input int r);
      logic [W-1:0] o;
      int           s;
      o = '0;
      for (int c = 0; c < W; c++) begin
         s = 0;
         for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
               if (r+dr >= 0 && r+dr < H && c+dc >= 0 && c+dc < W)
                  s += int'(src[r+dr][c+dc]);
         o[c] = (s == 3) || (src[r][c] && s == 4);
      end
      return o;
   endfunction

   task automatic load(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] d,
                       input logic [W-1:0] e);
      src[0] = a; src[1] = b; src[2] = c; src[3] = d; src[4] = e;
   endtask

   task automatic run_gen(input string name, input int repulse,
                          input int rst_at);
      int nwr, ndone, done_at, busy_bad, rd_bad, post_bad, gen_at, rel, t0;
      int wr_cyc [16];
      int wr_adr [16];
      bit bexp, cut;
      nwr = 0; ndone = 0; done_at = -1; busy_bad = 0;
      rd_bad = 0; post_bad = 0; gen_at = -1;
      for (int r = 0; r < H; r++) dst[r] = 'x;
      @(negedge clk);
      start = 1'b1;
      t0 = cyc;
      for (int k = 0; k < 3*H+6; k++) begin
         @(negedge clk);
         rel   = cyc - t0;
         start = (rel == repulse);
         reset = (rel == rst_at);
         cut   = (rst_at >= 0) && (rel > rst_at);
         bexp  = (rel >= 1) && (rel <= 3*H+3) && !cut;
         if (busy !== bexp) busy_bad++;
         if (rd_en && int'(rd_addr) >= H) rd_bad++;
         if (cut && (rd_en || wr_en || gen_count != 0)) post_bad++;
         if (wr_en && !cut) begin
            if (nwr < 16) begin
               wr_cyc[nwr] = rel;
               wr_adr[nwr] = int'(wr_addr);
            end
            nwr++;
            if (int'(wr_addr) < H) dst[wr_addr] = wr_data;
         end
         if (done) begin
            ndone++;
            done_at = rel;
         end
         if (rel == 3*H+4) gen_at = int'(gen_count);
      end
      start = 1'b0;
      reset = 1'b0;
      check($sformatf("%s busy", name), busy_bad, 0);
      check($sformatf("%s rd_range", name), rd_bad, 0);
      if (rst_at >= 0) begin
         check($sformatf("%s post_reset", name), post_bad, 0);
         gen_exp = 0;
      end else begin
         gen_exp++;
         check($sformatf("%s wr_count", name), nwr, H);
         for (int k = 0; k < H && k < nwr; k++) begin
            check($sformatf("%s wr_cyc%0d", name, k), wr_cyc[k], 5+3*k);
            check($sformatf("%s wr_adr%0d", name, k), wr_adr[k], k);
         end
         check($sformatf("%s done_cnt", name), ndone, 1);
         check($sformatf("%s done_cyc", name), done_at, 3*H+3);
         check($sformatf("%s gen", name), gen_at, gen_exp & 16'hFFFF);
         for (int r = 0; r < H; r++)
            check($sformatf("%s row%0d", name, r), dst[r], ref_row(r));
      end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      load('0, '0, '0, '0, '0);
      repeat (3) @(negedge clk);
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst rd_en", rd_en, 0);
      check("rst wr_en", wr_en, 0);
      check("rst rd_addr", rd_addr, 0);
      check("rst wr_addr", wr_addr, 0);
      check("rst gen", gen_count, 0);
      reset = 1'b0;

      load(8'h00, 8'h08, 8'h08, 8'h08, 8'h00);
      run_gen("blinker", -1, -1);
      check("blinker row2", dst[2], 8'h1C);
      check("blinker row1", dst[1], 8'h00);

      load(8'h03, 8'h03, 8'h00, 8'h00, 8'h00);
      run_gen("block", 6, -1);
      check("block row0", dst[0], 8'h03);
      check("block row1", dst[1], 8'h03);

      load(8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);
      run_gen("line", 3*H+3, -1);
      check("line row0", dst[0], 8'h7E);
      check("line row1", dst[1], 8'h7E);
      check("line row2", dst[2], 8'h00);

      load(8'h81, 8'h00, 8'h00, 8'h00, 8'h00);
      run_gen("nowrap", -1, -1);
      check("nowrap row0", dst[0], 8'h00);
      check("nowrap row4", dst[4], 8'h00);

      load(8'h00, 8'h1C, 8'h00, 8'h00, 8'h00);
      run_gen("abort", -1, 7);
      run_gen("restart", -1, -1);
      check("restart row0", dst[0], 8'h08);

      for (int n = 0; n < 10; n++) begin
         for (int r = 0; r < H; r++) src[r] = W'($urandom);
         run_gen($sformatf("rand%0d", n), int'($urandom_range(2, 18)), -1);
      end

      load(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
      run_gen("full", -1, -1);
      check("full row0", dst[0], 8'h81);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
